// File: rtl/cam_ram_writer.sv
// Streams 288-bit CAM entries into a 36-bit-wide RAM as eight consecutive words.
// A one-deep pending buffer lets the next entry start right after the current one.
module cam_ram_writer #(
    parameter int CAM_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(CAM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_index,
    input  logic [287:0]      req_data,
    output logic [ADDR_W+2:0] addra,
    output logic              wea,
    output logic [35:0]       dina,
    output logic              wr_busy,
    output logic [ADDR_W-1:0] wr_busy_index,
    output logic              wr_done,
    output logic              wr_err,
    output logic [15:0]       wr_count
);
    localparam int WW = 36;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(CAM_DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          word_q, word_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [287:0]        data_q, data_d;
    logic                pb_full_q, pb_full_d;
    logic [ADDR_W-1:0]   pb_idx_q, pb_idx_d;
    logic [287:0]        pb_data_q, pb_data_d;
    logic [ADDR_W+2:0]   addra_q, addra_d;
    logic                wea_q, wea_d;
    logic [35:0]         dina_q, dina_d;
    logic                wr_done_q, wr_done_d;
    logic                wr_err_q, wr_err_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic accept, in_range;

    assign req_ready = ~pb_full_q;
    assign accept    = req_valid & ~pb_full_q;
    assign in_range  = {1'b0, req_index} < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        data_d     = data_q;
        pb_full_d  = pb_full_q;
        pb_idx_d   = pb_idx_q;
        pb_data_d  = pb_data_q;
        wr_done_d  = 1'b0;
        wr_err_d   = accept & ~in_range;
        wr_count_d = wr_count_q;
        wea_d      = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;

        case (state_q)
            IDLE: begin
                if (accept && in_range) begin
                    state_d = WRITE;
                    word_d  = 3'd0;
                    idx_d   = req_index;
                    data_d  = req_data;
                end
            end
            WRITE: begin
                if (word_q != 3'd7) begin
                    word_d = word_q + 3'd1;
                    if (accept && in_range) begin
                        pb_full_d = 1'b1;
                        pb_idx_d  = req_index;
                        pb_data_d = req_data;
                    end
                end else begin
                    wr_done_d  = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                    word_d     = 3'd0;
                    // Chain the next entry with no idle cycle: buffered one first,
                    // otherwise a request arriving on the last word goes straight in.
                    if (pb_full_q) begin
                        idx_d     = pb_idx_q;
                        data_d    = pb_data_q;
                        pb_full_d = 1'b0;
                    end else if (accept && in_range) begin
                        idx_d  = req_index;
                        data_d = req_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // RAM port is registered from next-state values so it lines up with state_q.
        if (state_d == WRITE) begin
            wea_d   = 1'b1;
            addra_d = {idx_d, word_d};
            dina_d  = data_d[int'(word_d)*WW +: WW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            pb_full_q  <= 1'b0;
            pb_idx_q   <= '0;
            pb_data_q  <= '0;
            addra_q    <= '0;
            wea_q      <= 1'b0;
            dina_q     <= '0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            pb_full_q  <= pb_full_d;
            pb_idx_q   <= pb_idx_d;
            pb_data_q  <= pb_data_d;
            addra_q    <= addra_d;
            wea_q      <= wea_d;
            dina_q     <= dina_d;
            wr_done_q  <= wr_done_d;
            wr_err_q   <= wr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign addra         = addra_q;
    assign wea           = wea_q;
    assign dina          = dina_q;
    assign wr_busy       = (state_q == WRITE);
    assign wr_busy_index = idx_q;
    assign wr_done       = wr_done_q;
    assign wr_err        = wr_err_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_cam_ram_writer.sv
// Scoreboard bench for cam_ram_writer: stimulus pushes expected RAM words and
// done/err pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_cam_ram_writer;
    localparam int CAM_DEPTH = 1024;
    localparam int ADDR_W    = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_index;
    logic [287:0]      req_data;
    logic [ADDR_W+2:0] addra;
    logic              wea;
    logic [35:0]       dina;
    logic              wr_busy;
    logic [ADDR_W-1:0] wr_busy_index;
    logic              wr_done;
    logic              wr_err;
    logic [15:0]       wr_count;

    cam_ram_writer #(.CAM_DEPTH(CAM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_data(req_data),
        .addra(addra), .wea(wea), .dina(dina),
        .wr_busy(wr_busy), .wr_busy_index(wr_busy_index),
        .wr_done(wr_done), .wr_err(wr_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [ADDR_W+2:0] addr;
        logic [35:0]       data;
        logic [ADDR_W-1:0] idx;
    } wr_t;
    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } done_t;

    wr_t   exp_w[$];
    done_t exp_d[$];
    int    exp_e[$];

    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          last_end = -10;
    logic [15:0] exp_count = 16'd0;
    int          run = 0;
    int          max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [287:0] mk(input int s);
        logic [287:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[36*k +: 36] = 36'(s * 256 + k * 16);
        return d;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (wea) begin
            run++;
            if (exp_w.size() == 0) chk("wea_unexpected", 1, 0);
            else begin
                wr_t e;
                e = exp_w.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("addra", addra, e.addr);
                chk("dina", dina, e.data);
                chk("busy_in_write", wr_busy, 1);
                chk("busy_index", wr_busy_index, e.idx);
            end
        end else begin
            if (run > max_run) max_run = run;
            run = 0;
            chk("busy_outside_write", wr_busy, 0);
        end
        if (wr_done) begin
            if (exp_d.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                done_t d;
                d = exp_d.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_count", wr_count, d.cnt);
            end
        end
        if (wr_err) begin
            if (exp_e.size() == 0) chk("err_unexpected", 1, 0);
            else chk("err_cycle", cyc, exp_e.pop_front());
        end
    end

    task automatic send(input logic [ADDR_W-1:0] idx, input logic [287:0] d,
                        output int waited, output int t_acc);
        int start;
        req_valid = 1'b1;
        req_index = idx;
        req_data  = d;
        waited    = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        t_acc = cyc;
        if (idx < CAM_DEPTH) begin
            start = (last_end >= t_acc + 1) ? last_end + 1 : t_acc + 1;
            for (int k = 0; k < 8; k++) begin
                wr_t w;
                w.cyc  = start + k;
                w.addr = {idx, 3'(k)};
                w.data = d[36*k +: 36];
                w.idx  = idx;
                exp_w.push_back(w);
            end
            last_end = start + 7;
            exp_count = exp_count + 16'd1;
            begin
                done_t dd;
                dd.cyc = start + 8;
                dd.cnt = exp_count;
                exp_d.push_back(dd);
            end
        end else begin
            exp_e.push_back(t_acc + 1);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_w.size() != 0 || exp_d.size() != 0 || exp_e.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, t, ta;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_busy", wr_busy, 0);
        chk("rst_busy_index", wr_busy_index, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_count", wr_count, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", req_ready, 1);

        // single entry, index 5 -> addra 40..47, done at T+9
        send(11'd5, mk(0), w, t);
        wait_idle();
        chk("count_single", wr_count, 16'd1);

        // three back-to-back: third waits 7 cycles while PB is full
        max_run = 0;
        send(11'd1, mk(1), w, t);
        send(11'd2, mk(2), w, t);
        chk("second_no_wait", w, 0);
        send(11'd3, mk(3), w, t);
        chk("third_waited_pb_full", w, 7);
        wait_idle();
        chk("b2b_run_len", max_run, 24);
        chk("count_b2b", wr_count, 16'd4);

        // out of range
        send(11'd1024, mk(4), w, t);
        wait_idle();
        chk("count_after_oor", wr_count, 16'd4);

        // reset at word 3 with PB full
        send(11'd9, mk(5), w, ta);
        send(11'd10, mk(6), w, t);
        chk("pb_loaded_ready_low", req_ready, 0);
        while (cyc < ta + 4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_wea", wea, 0);
        chk("mid_reset_busy", wr_busy, 0);
        chk("mid_reset_count", wr_count, 0);
        exp_w.delete();
        exp_d.delete();
        exp_e.delete();
        last_end = -10;
        exp_count = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_mid_reset", req_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        send(11'd12, mk(7), w, t);
        wait_idle();
        chk("count_after_reset", wr_count, 16'd1);

        // wrap of wr_count
        @(negedge clk);
        force dut.wr_count_q = 16'hFFFF;
        #1 release dut.wr_count_q;
        exp_count = 16'hFFFF;
        @(posedge clk);
        #1 chk("count_preload", wr_count, 16'hFFFF);
        send(11'd20, mk(8), w, t);
        wait_idle();
        chk("count_wrap", wr_count, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d expected completion", cyc);
        $fatal(1);
    end
endmodule

// File: doc/cam_ram_writer.md
CAM_RAM_WRITER -- requirements
Module: cam_ram_writer

Interface
REQ-001 The block SHALL have parameter CAM_DEPTH, default 1024, meaning the number of 288-bit entries in the downstream CAM RAM (multiple of 1024).
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(CAM_DEPTH), meaning the entry index width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning an entry write request is presented.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the request is accepted on this cycle when req_valid is also high.
REQ-007 The block SHALL have port req_index, input, ADDR_W, the target entry index.
REQ-008 The block SHALL have port req_data, input, 288, the entry (action + tuple).
REQ-009 The block SHALL have port addra, output, ADDR_W+3, the RAM write address {index, word[2:0]}.
REQ-010 The block SHALL have port wea, output, 1, the RAM write enable.
REQ-011 The block SHALL have port dina, output, 36, the RAM write word.
REQ-012 The block SHALL have port wr_busy, output, 1, meaning an entry is partially written.
REQ-013 The block SHALL have port wr_busy_index, output, ADDR_W, the index being written while wr_busy is high.
REQ-014 The block SHALL have port wr_done, output, 1, a one-cycle pulse after the last word of an entry is written.
REQ-015 The block SHALL have port wr_err, output, 1, a one-cycle pulse when a request is dropped for req_index >= CAM_DEPTH.
REQ-016 The block SHALL have port wr_count, output, 16, the count of completed entries, wrapping.

Function
REQ-017 The block SHALL implement states IDLE and WRITE, plus a 3-bit word counter and a 1-deep pending buffer (PB).
REQ-018 req_ready SHALL equal NOT PB_full; acceptance is req_valid AND req_ready.
REQ-019 In IDLE with PB empty, an accepted in-range request SHALL load the active registers directly, and the block SHALL enter WRITE next cycle with word=0.
REQ-020 In WRITE, an accepted request SHALL be stored in PB; at most one request is buffered.
REQ-021 In WRITE, each cycle SHALL drive wea=1, addra={index, word}, and dina=data[36*word+35 -: 36]; word increments 0 to 7, so word 0 (bits 35:0) is written first.
REQ-022 Latency: for a request accepted at cycle T in IDLE, word 0 SHALL appear at T+1, word 7 at T+8, and wr_done at T+9.
REQ-023 After word 7, if PB is full, the PB entry SHALL move to active and its word 0 SHALL be driven at the very next cycle (no bubble; sustained 8 cycles/entry); otherwise the block returns to IDLE.
REQ-024 The PB SHALL be freed in the cycle its contents move to active; req_ready may rise that same cycle.
REQ-025 An out-of-range request SHALL be accepted, never written, never buffered, and SHALL pulse wr_err in the cycle after acceptance.
REQ-026 wr_busy SHALL be high exactly during WRITE cycles, with wr_busy_index equal to the active index.
REQ-027 Outside WRITE, wea SHALL be 0; addra and dina SHALL hold their last value.
REQ-028 wr_done SHALL pulse once per entry; wr_count SHALL increment with each wr_done and wrap from 0xFFFF to 0.
REQ-029 Simultaneous events: acceptance, a wr_done pulse, and a PB-to-active transfer in the same cycle SHALL all take effect.

Reset
REQ-030 On reset the block SHALL asynchronously enter IDLE with PB empty and word=0, and SHALL hold wea=0, addra=0, dina=0, wr_busy=0, wr_busy_index=0, wr_done=0, wr_err=0, and wr_count=0; req_ready SHALL be 1 in the first cycle after deassertion.
REQ-031 Reset mid-WRITE SHALL abandon the partial entry and drop PB contents with no further writes and no wr_done; software rewrites the entry.

Verification
REQ-032 The bench SHALL check a single request: index=5, data word k = 36'h0000000k0 -> addra 40..47 with wea over 8 cycles, dina word k correct, wr_done at T+9, and wr_count=1.
REQ-033 The bench SHALL check three back-to-back requests with req_valid held high -> req_ready low while PB is full, 24 consecutive wea cycles with no gap, and 3 wr_done pulses 8 cycles apart.
REQ-034 The bench SHALL check out-of-range index=CAM_DEPTH -> wr_err pulse at T+1, no wea, and wr_count unchanged.
REQ-035 The bench SHALL check reset asserted at word 3 with PB full -> wea=0 immediately, no wr_done, req_ready=1 after release, and the next request writing word 0 first.
REQ-036 The bench SHALL check wr_busy and wr_busy_index -> high with the correct index only during the 8 write cycles of each entry.
REQ-037 The bench SHALL preload wr_count to 0xFFFF via 65535 writes (or a force) -> the next wr_done gives wr_count=0.
